// File: rtl/mdu_pkg.sv
// Shared types, constants and op-decode helpers for the iterative
// RV32M multiply/divide unit.
package mdu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

   localparam logic [XLEN-1:0] DIV0_QUO     = '1;
   localparam logic [XLEN-1:0] OVF_DIVIDEND = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] OVF_DIVISOR  = '1;

   function automatic logic is_div(mdu_op_t op);
      return op[2];
   endfunction

   function automatic logic is_rem(mdu_op_t op);
      return op[2] & op[1];
   endfunction

   function automatic logic a_signed(mdu_op_t op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic b_signed(mdu_op_t op);
      return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage <-> MDU bundle: operands and op in, stall/done/result out.
// The pipeline drives through master, the MDU receives through slave.
interface mdu_if
   import mdu_pkg::*;
#(
   parameter int WIDTH = XLEN
) ();

   logic             mdu_start_E;
   logic [2:0]       mdu_op_E;
   logic [WIDTH-1:0] srcA_E;
   logic [WIDTH-1:0] srcB_E;
   logic             flush_E;
   logic             mdu_stall;
   logic             mdu_done;
   logic [WIDTH-1:0] mdu_result;

   modport master (
      output mdu_start_E, mdu_op_E, srcA_E, srcB_E, flush_E,
      input  mdu_stall, mdu_done, mdu_result
   );

   modport slave (
      input  mdu_start_E, mdu_op_E, srcA_E, srcB_E, flush_E,
      output mdu_stall, mdu_done, mdu_result
   );

endinterface

// File: rtl/mdu_sign_fix.sv
// Applies the result sign to the unsigned-magnitude product, quotient
// or remainder and selects the architectural result word.
module mdu_sign_fix
   import mdu_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic [2*WIDTH-1:0] i_prod,
   input  logic [WIDTH-1:0]   i_quo,
   input  logic [WIDTH-1:0]   i_rem,
   input  mdu_op_t            i_op,
   input  logic               i_qneg,
   input  logic               i_rneg,
   output logic [WIDTH-1:0]   o_word
);

   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   assign w_prod = i_qneg ? -i_prod : i_prod;
   assign w_quo  = i_qneg ? -i_quo  : i_quo;
   assign w_rem  = i_rneg ? -i_rem  : i_rem;

   always_comb begin
      o_word = w_rem;
      case (i_op)
         OP_MUL:                       o_word = w_prod[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: o_word = w_prod[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:              o_word = w_quo;
         default:                      o_word = w_rem;
      endcase
   end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, stalling the front of the pipe while busy.
module mdu_iterative
   import mdu_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic  clk,
   input  logic  rst,
   mdu_if.slave  bus
);

   localparam int CW = $clog2(WIDTH + 1);

   mdu_state_t         r_state, w_state_nxt;
   mdu_op_t            r_op, w_op;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_mcand, r_div, r_quo, r_rem, r_result;
   logic [2*WIDTH-1:0] r_prod;
   logic               r_qneg, r_rneg, r_done;

   logic               w_accept, w_last, w_stall;
   logic               w_aneg, w_bneg, w_div0, w_ovf, w_special;
   logic [WIDTH-1:0]   w_a_abs, w_b_abs, w_special_res;
   logic [WIDTH:0]     w_hi_sum, w_shift, w_trial;
   logic               w_ge;
   logic [2*WIDTH-1:0] w_prod_nxt;
   logic [WIDTH-1:0]   w_quo_nxt, w_rem_nxt, w_fix;

   assign w_op    = mdu_op_t'(bus.mdu_op_E);
   assign w_aneg  = a_signed(w_op) & bus.srcA_E[WIDTH-1];
   assign w_bneg  = b_signed(w_op) & bus.srcB_E[WIDTH-1];
   assign w_a_abs = w_aneg ? -bus.srcA_E : bus.srcA_E;
   assign w_b_abs = w_bneg ? -bus.srcB_E : bus.srcB_E;

   assign w_div0 = is_div(w_op) && (bus.srcB_E == '0);
   assign w_ovf  = (w_op == OP_DIV || w_op == OP_REM)
                && (bus.srcA_E == OVF_DIVIDEND)
                && (bus.srcB_E == OVF_DIVISOR);
   assign w_special = w_div0 | w_ovf;

   always_comb begin
      w_special_res = '0;
      if (w_div0)
         w_special_res = is_rem(w_op) ? bus.srcA_E : DIV0_QUO;
      else if (w_ovf)
         w_special_res = is_rem(w_op) ? '0 : OVF_DIVIDEND;
   end

   // Multiplier sits in the low half and is shifted out as the sum moves in.
   assign w_hi_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                     + (r_prod[0] ? {1'b0, r_mcand} : '0);
   assign w_prod_nxt = {w_hi_sum, r_prod[WIDTH-1:1]};

   // Partial remainder < divisor, so a WIDTH+1-bit trial never overflows.
   assign w_shift   = {r_rem, r_quo[WIDTH-1]};
   assign w_trial   = w_shift - {1'b0, r_div};
   assign w_ge      = ~w_trial[WIDTH];
   assign w_rem_nxt = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

   mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
      .i_prod (w_prod_nxt),
      .i_quo  (w_quo_nxt),
      .i_rem  (w_rem_nxt),
      .i_op   (r_op),
      .i_qneg (r_qneg),
      .i_rneg (r_rneg),
      .o_word (w_fix)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      w_stall     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.mdu_start_E && !bus.flush_E) begin
               w_accept    = 1'b1;
               w_stall     = 1'b1;
               w_state_nxt = w_special ? DONE : CALC;
            end
         end
         CALC: begin
            if (bus.flush_E) begin
               w_state_nxt = IDLE;
            end else begin
               w_stall = 1'b1;
               if (r_cnt == CW'(1)) begin
                  w_last      = 1'b1;
                  w_state_nxt = DONE;
               end
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_op     <= OP_MUL;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_div    <= '0;
         r_quo    <= '0;
         r_rem    <= '0;
         r_prod   <= '0;
         r_qneg   <= 1'b0;
         r_rneg   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (w_state_nxt == DONE);
         if (w_accept) begin
            r_op    <= w_op;
            r_cnt   <= CW'(WIDTH);
            r_mcand <= w_a_abs;
            r_prod  <= {{WIDTH{1'b0}}, w_b_abs};
            r_quo   <= w_a_abs;
            r_div   <= w_b_abs;
            r_rem   <= '0;
            r_qneg  <= w_aneg ^ w_bneg;
            r_rneg  <= w_aneg;
            if (w_special)
               r_result <= w_special_res;
         end else if (r_state == CALC) begin
            r_cnt  <= r_cnt - CW'(1);
            r_prod <= w_prod_nxt;
            r_quo  <= w_quo_nxt;
            r_rem  <= w_rem_nxt;
            if (w_last)
               r_result <= w_fix;
         end
      end
   end

   assign bus.mdu_stall  = w_stall;
   assign bus.mdu_done   = r_done;
   assign bus.mdu_result = r_result;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: directed corner cases plus random
// ops checked against a plain-arithmetic RV32M reference.
module tb_mdu_iterative;
   import mdu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mdu_if #(.WIDTH(32)) bus();

   mdu_iterative #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      int          c0;
      int          lat;
   } exp_t;

   exp_t        q[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic [31:0] last_res = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   function automatic logic is_special(input logic [2:0] op,
                                       input logic [31:0] a, b);
      return (op[2] && b == 32'h0)
          || ((op == 3'd4 || op == 3'd6)
              && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] ref_model(input logic [2:0] op,
                                             input logic [31:0] a, b);
      logic [63:0] sa, sb, ua, ub, p;
      int          ia, ib;
      logic [31:0] r;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'h0, a};
      ub = {32'h0, b};
      ia = a;
      ib = b;
      r  = '0;
      case (op)
         3'd0: begin p = ua * ub; r = p[31:0];  end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               r = 32'h8000_0000;
            else r = ia / ib;
         end
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
            else r = ia % ib;
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Monitor: pops one expectation per done pulse.
   always @(negedge clk) begin
      if (!rst && bus.mdu_done === 1'b1) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_done: got done=1 required 0, result %h",
                     bus.mdu_result);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("result", bus.mdu_result, e.res);
            check("latency", 32'(cyc - e.c0), 32'(e.lat));
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, b,
                        input bit noise, input bit hold);
      exp_t e;
      int   n;
      int   bad;
      bit   seen;
      @(posedge clk); #1;
      bus.mdu_op_E    = op;
      bus.srcA_E      = a;
      bus.srcB_E      = b;
      bus.mdu_start_E = 1'b1;
      e.res = ref_model(op, a, b);
      e.c0  = cyc;
      e.lat = is_special(op, a, b) ? 1 : 33;
      q.push_back(e);
      last_res = e.res;
      n    = 0;
      bad  = 0;
      seen = 1'b0;
      @(negedge clk);
      if (bus.mdu_stall !== 1'b1) bad++;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         seen = (bus.mdu_done === 1'b1);
         if (!hold) begin
            if (noise && !seen) begin
               bus.mdu_start_E = 1'($urandom_range(0, 1));
               bus.mdu_op_E    = 3'($urandom);
               bus.srcA_E      = $urandom;
               bus.srcB_E      = $urandom;
            end else begin
               bus.mdu_start_E = 1'b0;
            end
         end
         @(negedge clk);
         if (bus.mdu_stall !== (seen ? 1'b0 : 1'b1)) bad++;
      end
      check("done_seen", 32'(seen), 32'd1);
      check("stall_profile", 32'(bad), 32'd0);
   endtask

   task automatic abort_at_10(input bit use_rst);
      @(posedge clk); #1;
      bus.mdu_op_E    = 3'd0;
      bus.srcA_E      = 32'h1234_5678;
      bus.srcB_E      = 32'h0000_0777;
      bus.mdu_start_E = 1'b1;
      @(posedge clk); #1;
      bus.mdu_start_E = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      if (use_rst) rst = 1'b1;
      else bus.flush_E = 1'b1;
      @(negedge clk);
      if (!use_rst) check("flush_stall", 32'(bus.mdu_stall), 32'd0);
      @(posedge clk); #1;
      rst         = 1'b0;
      bus.flush_E = 1'b0;
      if (use_rst) last_res = '0;
      @(negedge clk);
      check(use_rst ? "rst_stall" : "flush_idle_stall",
            32'(bus.mdu_stall), 32'd0);
      check(use_rst ? "rst_done" : "flush_done",
            32'(bus.mdu_done), 32'd0);
      check(use_rst ? "rst_result" : "flush_result",
            bus.mdu_result, last_res);
      repeat (40) @(posedge clk);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0:       v = 32'h0;
         1:       v = 32'h1;
         2:       v = 32'hFFFF_FFFF;
         3:       v = 32'h8000_0000;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      bus.mdu_start_E = 1'b0;
      bus.mdu_op_E    = 3'd0;
      bus.srcA_E      = '0;
      bus.srcB_E      = '0;
      bus.flush_E     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_done", 32'(bus.mdu_done), 32'd0);
      check("reset_result", bus.mdu_result, 32'd0);
      check("reset_stall", 32'(bus.mdu_stall), 32'd0);

      issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
      check("mul_7_m3", bus.mdu_result, 32'hFFFF_FFEB);
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check("mulhu_ones", bus.mdu_result, 32'hFFFF_FFFE);
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check("mulh_ones", bus.mdu_result, 32'h0000_0000);
      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check("mulhsu_ones", bus.mdu_result, 32'hFFFF_FFFF);
      issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      check("div_m7_2", bus.mdu_result, 32'hFFFF_FFFD);
      issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      check("rem_m7_2", bus.mdu_result, 32'hFFFF_FFFF);
      issue(3'd5, 32'd100, 32'd7, 1'b0, 1'b0);
      check("divu_100_7", bus.mdu_result, 32'd14);
      issue(3'd7, 32'd100, 32'd7, 1'b0, 1'b0);
      check("remu_100_7", bus.mdu_result, 32'd2);
      issue(3'd5, 32'd5, 32'd0, 1'b0, 1'b0);
      check("divu_by0", bus.mdu_result, 32'hFFFF_FFFF);
      issue(3'd7, 32'd5, 32'd0, 1'b0, 1'b0);
      check("remu_by0", bus.mdu_result, 32'd5);
      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check("div_ovf", bus.mdu_result, 32'h8000_0000);
      issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check("rem_ovf", bus.mdu_result, 32'h0);

      abort_at_10(1'b0);
      abort_at_10(1'b1);

      // flush in IDLE must block the accept
      @(posedge clk); #1;
      bus.mdu_op_E    = 3'd5;
      bus.srcA_E      = 32'd9;
      bus.srcB_E      = 32'd4;
      bus.mdu_start_E = 1'b1;
      bus.flush_E     = 1'b1;
      @(negedge clk);
      check("idle_flush_stall", 32'(bus.mdu_stall), 32'd0);
      @(posedge clk); #1;
      bus.mdu_start_E = 1'b0;
      bus.flush_E     = 1'b0;
      @(negedge clk);
      check("idle_flush_noacc", 32'(bus.mdu_stall), 32'd0);
      repeat (40) @(posedge clk);

      // start held through DONE, then a fresh op the cycle after
      issue(3'd5, 32'd100, 32'd7, 1'b0, 1'b1);
      bus.srcA_E = 32'h10;
      bus.srcB_E = 32'd3;
      issue(3'd5, 32'h10, 32'd3, 1'b0, 1'b0);
      check("b2b_divu", bus.mdu_result, 32'd5);

      for (int i = 0; i < 40; i++)
         issue(3'($urandom_range(0, 7)), pick(), pick(), 1'b1, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      bus.mdu_start_E = 1'b0;
      repeat (5) @(posedge clk);
      check("drain", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
